// File: rtl/dc_pkg.sv
// Shared types and default constants for the dc MMCM phase-shift controller.
package dc_pkg;

   typedef enum logic [1:0] {
      PS_IDLE,
      PS_ISSUE,
      PS_WAIT,
      PS_SETTLE
   } ps_state_t;

   localparam int unsigned PEND_WIDTH_DEF  = 6;
   localparam int unsigned POS_WIDTH_DEF   = 16;
   localparam int unsigned SETTLE_CYC_DEF  = 8;
   localparam int unsigned TIMEOUT_CYC_DEF = 1024;

   // Bits needed to count 0 .. max(a,b)-1 in the shared wait/settle counter.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/mmcm_ps_ctrl.sv
// Nets phase step requests into a saturating signed backlog and issues them one at a
// time on the MMCM dynamic phase-shift port, tracking applied position and errors.
module mmcm_ps_ctrl
   import dc_pkg::*;
#(
   parameter int unsigned PEND_WIDTH  = PEND_WIDTH_DEF,
   parameter int unsigned POS_WIDTH   = POS_WIDTH_DEF,
   parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic                         ph_inc,
   input  logic                         ph_dec,
   output logic                         psen,
   output logic                         psincdec,
   input  logic                         psdone,
   output logic                         busy,
   output logic signed [POS_WIDTH-1:0]  pos,
   output logic signed [PEND_WIDTH-1:0] pending,
   output logic                         err_timeout,
   output logic                         err_ovf,
   input  logic                         clr
);

   localparam int unsigned PX    = PEND_WIDTH + 1;
   localparam int unsigned CNT_W = cnt_width(SETTLE_CYC, TIMEOUT_CYC);

   localparam logic signed [PX-1:0] ONE   = PX'(1);
   localparam logic signed [PX-1:0] MONE  = -ONE;
   localparam logic signed [PX-1:0] PMAX  = PX'((1 << (PEND_WIDTH - 1)) - 1);
   localparam logic [CNT_W-1:0]     TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   ps_state_t                    state_q;
   logic signed [PEND_WIDTH-1:0] pending_q, pending_d;
   logic signed [POS_WIDTH-1:0]  pos_q;
   logic [CNT_W-1:0]             cnt_q;
   logic                         psen_q, dir_q, tmo_q, ovf_q;

   logic                         issue_c, drop_c, done_c, tmo_c;
   logic signed [PX-1:0]         pend_x, step_x, req_x, base_x, sum_x;

   // Backlog next value: issued step and new request are netted in the same cycle.
   always_comb begin
      issue_c = (state_q == PS_IDLE) && ena && (pending_q != '0);
      pend_x  = {pending_q[PEND_WIDTH-1], pending_q};
      step_x  = '0;
      if (issue_c) begin
         step_x = pending_q[PEND_WIDTH-1] ? ONE : MONE;
      end
      req_x = '0;
      if (ph_inc && !ph_dec) begin
         req_x = ONE;
      end else if (ph_dec && !ph_inc) begin
         req_x = MONE;
      end
      base_x    = pend_x + step_x;
      sum_x     = base_x + req_x;
      drop_c    = (sum_x > PMAX) || (sum_x < -PMAX);
      pending_d = drop_c ? base_x[PEND_WIDTH-1:0] : sum_x[PEND_WIDTH-1:0];
      if (!ena) begin
         pending_d = '0;
         drop_c    = 1'b0;
      end
      done_c = (state_q == PS_WAIT) && psdone;
      tmo_c  = (state_q == PS_WAIT) && !psdone && (cnt_q == TMO_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= PS_IDLE;
         pending_q <= '0;
         pos_q     <= '0;
         cnt_q     <= '0;
         psen_q    <= 1'b0;
         dir_q     <= 1'b0;
         tmo_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         psen_q    <= 1'b0;
         case (state_q)
            PS_IDLE: begin
               if (issue_c) begin
                  state_q <= PS_ISSUE;
                  psen_q  <= 1'b1;
                  dir_q   <= ~pending_q[PEND_WIDTH-1];
               end
               cnt_q <= '0;
            end
            PS_ISSUE: begin
               state_q <= PS_WAIT;
               cnt_q   <= '0;
            end
            PS_WAIT: begin
               if (done_c || tmo_c) begin
                  state_q <= PS_SETTLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            PS_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_q <= PS_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= PS_IDLE;
               cnt_q   <= '0;
            end
         endcase
         // clr takes priority over a coinciding completion or error.
         if (clr) begin
            pos_q <= '0;
            tmo_q <= 1'b0;
            ovf_q <= 1'b0;
         end else begin
            if (done_c) begin
               pos_q <= dir_q ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
            end
            if (tmo_c) begin
               tmo_q <= 1'b1;
            end
            if (drop_c) begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

   assign psen        = psen_q;
   assign psincdec    = dir_q;
   assign pos         = pos_q;
   assign pending     = pending_q;
   assign err_timeout = tmo_q;
   assign err_ovf     = ovf_q;
   assign busy        = (state_q != PS_IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_mmcm_ps_ctrl.sv
// Randomised bench for mmcm_ps_ctrl against a timeline model of step issue and completion.
module tb_mmcm_ps_ctrl;

   localparam int PW   = 6;
   localparam int QW   = 16;
   localparam int SET  = 8;
   localparam int TMO  = 1024;
   localparam int PMAX = 31;

   logic clk;
   logic rst_n, ena, ph_inc, ph_dec, psdone, clr;
   logic psen, psincdec, busy, err_timeout, err_ovf;
   logic signed [QW-1:0] pos;
   logic signed [PW-1:0] pending;

   int checks = 0;
   int errors = 0;

   // Model: backlog count, step timeline (issue edge, earliest next issue edge), position.
   int cyc = 0;
   int m_pend, m_ready_at, m_issue_at, m_pos;
   bit m_active, m_dir, m_psen, m_tmo, m_ovf;

   // MMCM responder and observation state.
   int resp_cnt = 0;
   int lat_fixed = 5;
   bit withhold = 0;
   bit spur_en = 0;
   int psen_cnt = 0;
   int last_psen = -1;

   mmcm_ps_ctrl #(
      .PEND_WIDTH(PW), .POS_WIDTH(QW), .SETTLE_CYC(SET), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ph_inc(ph_inc), .ph_dec(ph_dec),
      .psen(psen), .psincdec(psincdec), .psdone(psdone), .busy(busy),
      .pos(pos), .pending(pending), .err_timeout(err_timeout), .err_ovf(err_ovf),
      .clr(clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] u16(input int v);
      logic [15:0] t;
      t = v[15:0];
      return {16'b0, t};
   endfunction

   function automatic logic [31:0] u6(input int v);
      logic [5:0] t;
      t = v[5:0];
      return {26'b0, t};
   endfunction

   task automatic model_step();
      int base, nw;
      bit issue, done, tmo, ovf_set;
      cyc++;
      if (!rst_n) begin
         m_pend = 0; m_active = 0; m_dir = 0; m_psen = 0;
         m_pos = 0; m_tmo = 0; m_ovf = 0; m_ready_at = cyc + 1;
         return;
      end
      issue = !m_active && (cyc >= m_ready_at) && ena && (m_pend != 0);
      done = 0;
      tmo  = 0;
      if (m_active && cyc >= m_issue_at + 2) begin
         if (psdone) done = 1;
         else if (cyc == m_issue_at + 1 + TMO) tmo = 1;
      end
      if (done || tmo) begin
         m_active   = 0;
         m_ready_at = cyc + SET + 1;
      end
      if (done) m_pos += m_dir ? 1 : -1;
      if (issue) begin
         m_active   = 1;
         m_issue_at = cyc;
         m_dir      = (m_pend > 0);
      end
      ovf_set = 0;
      if (!ena) begin
         m_pend = 0;
      end else begin
         base = m_pend - (issue ? ((m_pend > 0) ? 1 : -1) : 0);
         nw   = base + int'(ph_inc) - int'(ph_dec);
         if (nw > PMAX || nw < -PMAX) begin
            nw      = base;
            ovf_set = 1;
         end
         m_pend = nw;
      end
      m_psen = issue;
      if (clr) begin
         m_pos = 0; m_tmo = 0; m_ovf = 0;
      end else begin
         if (tmo) m_tmo = 1;
         if (ovf_set) m_ovf = 1;
      end
   endtask

   task automatic tick();
      bit exp_busy;
      @(posedge clk);
      model_step();
      @(negedge clk);
      exp_busy = m_active || (cyc < m_ready_at - 1) || (m_pend != 0);
      check("psen", 32'(psen), 32'(m_psen));
      check("psincdec", 32'(psincdec), 32'(m_dir));
      check("busy", 32'(busy), 32'(exp_busy));
      check("pos", 32'($unsigned(pos)), u16(m_pos));
      check("pending", 32'($unsigned(pending)), u6(m_pend));
      check("err_timeout", 32'(err_timeout), 32'(m_tmo));
      check("err_ovf", 32'(err_ovf), 32'(m_ovf));
      if (psen === 1'b1) begin
         psen_cnt++;
         if (last_psen >= 0) check("psen_gap", 32'(cyc - last_psen >= SET + 2), 32'd1);
         last_psen = cyc;
      end
      if (!rst_n) last_psen = -1;
      ph_inc = 0; ph_dec = 0; clr = 0; psdone = 0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) psdone = 1;
      end else if (spur_en && $urandom_range(0, 31) == 0) begin
         psdone = 1;
      end
      if (psen === 1'b1 && !withhold)
         resp_cnt = (lat_fixed > 0) ? lat_fixed - 1 : int'($urandom_range(1, 7));
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (busy || resp_cnt > 0); i++) tick();
      check("drain_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int p0, n0;
      rst_n = 0; ena = 1; ph_inc = 0; ph_dec = 0; psdone = 0; clr = 0;
      tick(); tick();
      check("rst_pos", 32'($unsigned(pos)), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1;
      tick();

      // Single increment, psdone five cycles after psen.
      lat_fixed = 5; n0 = psen_cnt;
      ph_inc = 1; tick();
      drain(200);
      check("s1_pos", 32'($unsigned(pos)), u16(1));
      check("s1_psen_cnt", 32'(psen_cnt - n0), 32'd1);
      check("s1_dir", 32'(psincdec), 32'd1);

      // Burst of four decrements.
      clr = 1; tick();
      lat_fixed = 3; n0 = psen_cnt;
      for (int i = 0; i < 4; i++) begin ph_dec = 1; tick(); end
      drain(400);
      check("s2_pos", 32'($unsigned(pos)), u16(-4));
      check("s2_psen_cnt", 32'(psen_cnt - n0), 32'd4);

      // Simultaneous inc and dec cancel.
      n0 = psen_cnt;
      ph_inc = 1; ph_dec = 1; tick();
      tick(); tick();
      check("s3_pending", 32'($unsigned(pending)), 32'd0);
      check("s3_busy", 32'(busy), 32'd0);
      check("s3_psen_cnt", 32'(psen_cnt - n0), 32'd0);

      // Saturation and timeout with psdone withheld.
      withhold = 1; p0 = int'(pos);
      for (int i = 0; i < 40; i++) begin ph_inc = 1; tick(); end
      check("s4_pending_sat", 32'($unsigned(pending)), 32'd31);
      check("s4_ovf", 32'(err_ovf), 32'd1);
      for (int i = 0; i < TMO + 20 && !err_timeout; i++) tick();
      check("s4_tmo", 32'(err_timeout), 32'd1);
      check("s4_pos_hold", 32'($unsigned(pos)), u16(p0));
      withhold = 0;
      for (int i = 0; i < SET + 4; i++) tick();
      drain(3000);
      check("s4_pos_resume", 32'($unsigned(pos)), u16(p0 + 31));
      clr = 1; tick();
      check("s4_clr_tmo", 32'(err_timeout), 32'd0);
      check("s4_clr_ovf", 32'(err_ovf), 32'd0);

      // ena falls while a step is outstanding with three more pending.
      lat_fixed = 8; n0 = psen_cnt;
      for (int i = 0; i < 4; i++) begin ph_inc = 1; tick(); end
      check("s5_pending3", 32'($unsigned(pending)), 32'd3);
      ena = 0; tick();
      check("s5_flush", 32'($unsigned(pending)), 32'd0);
      drain(200);
      for (int i = 0; i < 10; i++) tick();
      check("s5_pos", 32'($unsigned(pos)), u16(1));
      check("s5_psen_cnt", 32'(psen_cnt - n0), 32'd1);
      ena = 1;
      for (int i = 0; i < 5; i++) tick();
      check("s5_no_more", 32'(psen_cnt - n0), 32'd1);

      // Asynchronous reset while waiting for psdone.
      n0 = psen_cnt;
      ph_inc = 1; tick();
      for (int i = 0; i < 20 && psen_cnt == n0; i++) tick();
      tick(); tick();
      #2 rst_n = 0;
      #1;
      check("ar_psen", 32'(psen), 32'd0);
      check("ar_dir", 32'(psincdec), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_pos", 32'($unsigned(pos)), 32'd0);
      check("ar_pending", 32'($unsigned(pending)), 32'd0);
      check("ar_errs", 32'({err_timeout, err_ovf}), 32'd0);
      tick(); tick();
      rst_n = 1;
      for (int i = 0; i < 12; i++) tick();
      check("ar_late_done", 32'($unsigned(pos)), 32'd0);

      // Randomised traffic with spurious psdone and occasional clr/ena drops.
      lat_fixed = 0; spur_en = 1;
      for (int i = 0; i < 2500; i++) begin
         ena    = ($urandom_range(0, 39) != 0);
         ph_inc = ($urandom_range(0, 3) == 0);
         ph_dec = ($urandom_range(0, 4) == 0);
         clr    = ($urandom_range(0, 199) == 0);
         tick();
      end
      ena = 1; spur_en = 0;
      drain(2000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
